// File: rtl/siso_arb_ctrl_if.sv
// siso_arb_ctrl_if
// Bundles the two requester valid/ready/data channels and the serial
// output lane (so, so_valid, frame_start, grant_id) of siso_arb_ctrl.
//   slave  modport : the arbiter (takes requests, drives ready and the lane)
//   master modport : the requester / consumer side
// Parameter:
//   WIDTH : bits per parallel word (2 or more)
interface siso_arb_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             so;
    logic             so_valid;
    logic             frame_start;
    logic             grant_id;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, so, so_valid, frame_start, grant_id
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, so, so_valid, frame_start, grant_id
    );
endinterface

// File: rtl/siso_arb_ctrl.sv
// siso_arb_ctrl
// Two-requester round-robin arbiter feeding a single serial shift lane.
// A granted word is loaded into a shift register and sent MSB-first, one
// bit per clock, on a registered output. A new word can be accepted while
// the last bit of the current frame is on the lane, so back-to-back frames
// have no gap.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset (aborts any frame in flight)
//   bus : siso_arb_ctrl_if.slave
//         req0/req1 valid, data in; req0/req1 ready out (combinational)
//         so, so_valid, frame_start, grant_id out (registered)
module siso_arb_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    siso_arb_ctrl_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sr_reg, sr_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             last_grant_reg, last_grant_next;
    logic             so_reg, so_next;
    logic             so_valid_reg, so_valid_next;
    logic             frame_start_reg, frame_start_next;
    logic             grant_id_reg, grant_id_next;

    logic             accept;
    logic             any_valid;
    logic             grant;
    logic             handshake;
    logic [WIDTH-1:0] grant_data;
    logic [1:0]       ready_vec;

    // Accept window: idle, or the last bit of the current frame is on so.
    // Held shut during reset so no word is consumed while rst is high.
    always_comb begin
        accept     = !rst && ((state_reg == IDLE) || (cnt_reg == '0));
        any_valid  = bus.req0_valid | bus.req1_valid;
        // On a tie the requester that did not win last time gets the lane;
        // otherwise the only active requester wins.
        if (bus.req0_valid && bus.req1_valid) begin
            grant = !last_grant_reg;
        end else begin
            grant = bus.req1_valid;
        end
        grant_data = grant ? bus.req1_data : bus.req0_data;
        handshake  = accept && any_valid;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign ready_vec[gi] = handshake && (grant == 1'(gi));
        end
    endgenerate

    assign bus.req0_ready  = ready_vec[0];
    assign bus.req1_ready  = ready_vec[1];
    assign bus.so          = so_reg;
    assign bus.so_valid    = so_valid_reg;
    assign bus.frame_start = frame_start_reg;
    assign bus.grant_id    = grant_id_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            sr_reg          <= '0;
            cnt_reg         <= '0;
            last_grant_reg  <= 1'b1;
            so_reg          <= 1'b0;
            so_valid_reg    <= 1'b0;
            frame_start_reg <= 1'b0;
            grant_id_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            sr_reg          <= sr_next;
            cnt_reg         <= cnt_next;
            last_grant_reg  <= last_grant_next;
            so_reg          <= so_next;
            so_valid_reg    <= so_valid_next;
            frame_start_reg <= frame_start_next;
            grant_id_reg    <= grant_id_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        sr_next          = sr_reg;
        cnt_next         = cnt_reg;
        last_grant_next  = last_grant_reg;
        so_next          = so_reg;
        so_valid_next    = so_valid_reg;
        frame_start_next = frame_start_reg;
        grant_id_next    = grant_id_reg;

        if (handshake) begin
            // MSB goes straight to so; the remaining bits wait in sr.
            sr_next          = {grant_data[WIDTH-2:0], 1'b0};
            so_next          = grant_data[WIDTH-1];
            so_valid_next    = 1'b1;
            frame_start_next = 1'b1;
            grant_id_next    = grant;
            last_grant_next  = grant;
            cnt_next         = CW'(WIDTH - 1);
            state_next       = SHIFT;
        end else if (state_reg == SHIFT) begin
            if (cnt_reg != '0) begin
                so_next          = sr_reg[WIDTH-1];
                sr_next          = {sr_reg[WIDTH-2:0], 1'b0};
                cnt_next         = cnt_reg - 1'b1;
                frame_start_next = 1'b0;
            end else begin
                so_next          = 1'b0;
                so_valid_next    = 1'b0;
                frame_start_next = 1'b0;
                state_next       = IDLE;
            end
        end
    end
endmodule

// File: tb/tb_siso_arb_ctrl.sv
module tb_siso_arb_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    siso_arb_ctrl_if #(.WIDTH(4)) bus4();
    siso_arb_ctrl_if #(.WIDTH(8)) bus8();

    siso_arb_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    siso_arb_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

    typedef struct packed {
        logic so;
        logic fs;
        logic gid;
    } ent_t;

    ent_t       sb[$];      // expected lane bits, oldest first
    logic [3:0] w0_q[$];    // words waiting at requester 0
    logic [3:0] w1_q[$];    // words waiting at requester 1
    logic       tb_last;
    logic       cur_gid;
    logic [5:0] obs;        // {so_valid, so, frame_start, grant_id, ready0, ready1}
    logic [5:0] expv;
    int         total;
    int         bad;

    // One clock of the 4-bit DUT: drive requesters from their queues, sample
    // at the falling edge, pop the expected lane value, predict readies from
    // the scoreboard depth and push a new frame when a handshake is due.
    task automatic step();
        ent_t       e;
        logic       v0, v1, acc, g, rst_edge;
        logic [3:0] d;
        v0 = (w0_q.size() != 0);
        v1 = (w1_q.size() != 0);
        bus4.req0_valid = v0;
        bus4.req0_data  = v0 ? w0_q[0] : 4'h0;
        bus4.req1_valid = v1;
        bus4.req1_data  = v1 ? w1_q[0] : 4'h0;
        @(negedge clk);
        obs = {bus4.so_valid, bus4.so, bus4.frame_start, bus4.grant_id,
               bus4.req0_ready, bus4.req1_ready};
        if (sb.size() != 0) begin
            e = sb.pop_front();
            expv[5:2] = {1'b1, e.so, e.fs, e.gid};
        end else begin
            expv[5:2] = {3'b000, cur_gid};
        end
        acc = !rst && (sb.size() == 0);
        g   = (v0 && v1) ? !tb_last : v1;
        expv[1] = acc && (v0 || v1) && !g;
        expv[0] = acc && (v0 || v1) && g;
        if (acc && (v0 || v1)) begin
            d = g ? w1_q.pop_front() : w0_q.pop_front();
            for (int i = 3; i >= 0; i--) begin
                e.so  = d[i];
                e.fs  = (i == 3);
                e.gid = g;
                sb.push_back(e);
            end
            tb_last = g;
            cur_gid = g;
        end
        rst_edge = rst;
        @(posedge clk);
        if (rst_edge) begin
            sb.delete();
            tb_last = 1'b1;
            cur_gid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        tb_last = 1'b1;
        cur_gid = 1'b0;
        w0_q.push_back(4'hA);
        w1_q.push_back(4'h5);
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (obs !== 6'b000000) begin
                bad++;
                $display("FAIL reset cyc%0d got=%b want=%b", k, obs, 6'b000000);
            end
        end
        w0_q.delete();
        w1_q.delete();
        rst = 1'b0;
    endtask

    task automatic test_simultaneous();
        int r0_at, r1_at, sov_cnt;
        r0_at = -1; r1_at = -1; sov_cnt = 0;
        w0_q.push_back(4'hA);
        w1_q.push_back(4'h5);
        for (int k = 0; k < 10; k++) begin
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL simul cyc%0d got=%b want=%b", k, obs, expv);
            end
            if (obs[1]) r0_at = k;
            if (obs[0]) r1_at = k;
            if (obs[5]) sov_cnt++;
        end
        total++;
        if (r0_at !== 0 || r1_at !== 4) begin
            bad++;
            $display("FAIL simul_ready_cycles got r0=%0d r1=%0d want r0=0 r1=4", r0_at, r1_at);
        end
        total++;
        if (sov_cnt !== 8) begin
            bad++;
            $display("FAIL simul_sov_count got=%0d want=8", sov_cnt);
        end
    endtask

    task automatic test_contention();
        int   n, r0_cnt, r1_cnt;
        logic started, gap;
        logic gseq[$];
        n = 0; r0_cnt = 0; r1_cnt = 0; started = 1'b0; gap = 1'b0;
        for (int k = 0; k < 6; k++) begin
            w0_q.push_back(4'($urandom_range(0, 15)));
            w1_q.push_back(4'($urandom_range(0, 15)));
        end
        while ((w0_q.size() + w1_q.size() + sb.size()) != 0 && n < 200) begin
            step();
            n++;
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL contention cyc%0d got=%b want=%b", n, obs, expv);
            end
            if (obs[1]) r0_cnt++;
            if (obs[0]) r1_cnt++;
            if (obs[3]) gseq.push_back(obs[2]);
            if (obs[5]) started = 1'b1;
            else if (started && (w0_q.size() + w1_q.size() + sb.size()) != 0) gap = 1'b1;
        end
        total++;
        if (n >= 200) begin
            bad++;
            $display("FAIL contention_timeout got=%0d cycles want<200", n);
        end
        total++;
        if (r0_cnt !== 6 || r1_cnt !== 6) begin
            bad++;
            $display("FAIL contention_ready_pulses got r0=%0d r1=%0d want 6 6", r0_cnt, r1_cnt);
        end
        total++;
        if (gap !== 1'b0) begin
            bad++;
            $display("FAIL contention_gap got=%b want=0", gap);
        end
        total++;
        if (gseq.size() !== 12) begin
            bad++;
            $display("FAIL contention_frames got=%0d want=12", gseq.size());
        end
        for (int k = 0; k < gseq.size(); k++) begin
            total++;
            if (gseq[k] !== 1'(k % 2)) begin
                bad++;
                $display("FAIL contention_gid%0d got=%b want=%b", k, gseq[k], 1'(k % 2));
            end
        end
    endtask

    task automatic test_late_req1();
        int n;
        w1_q.push_back(4'h3);
        for (int k = 0; k < 6; k++) begin
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL late1 cyc%0d got=%b want=%b", k, obs, expv);
            end
            if (k == 0) begin
                total++;
                if (obs[1:0] !== 2'b01) begin
                    bad++;
                    $display("FAIL late1_ready got=%b want=01", obs[1:0]);
                end
            end
        end
        w0_q.push_back(4'h9);
        w1_q.push_back(4'h6);
        step();
        total++;
        if (obs[1:0] !== 2'b10 || obs !== expv) begin
            bad++;
            $display("FAIL late1_next_tie got=%b want=%b", obs, expv);
        end
        n = 0;
        while ((w0_q.size() + w1_q.size() + sb.size()) != 0 && n < 20) begin
            step();
            n++;
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL late1_drain cyc%0d got=%b want=%b", n, obs, expv);
            end
        end
    endtask

    task automatic test_single();
        int r0_cnt;
        r0_cnt = 0;
        w0_q.push_back(4'b1011);
        for (int k = 0; k < 6; k++) begin
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL single cyc%0d got=%b want=%b", k, obs, expv);
            end
            if (obs[1]) r0_cnt++;
        end
        total++;
        if (r0_cnt !== 1) begin
            bad++;
            $display("FAIL single_ready_pulses got=%0d want=1", r0_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        int n;
        w0_q.push_back(4'hF);
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL midrst_pre cyc%0d got=%b want=%b", k, obs, expv);
            end
        end
        w0_q.push_back(4'h9);
        w1_q.push_back(4'h6);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            total++;
            if (obs !== expv || obs[1:0] !== 2'b00) begin
                bad++;
                $display("FAIL midrst_hold cyc%0d got=%b want=%b", k, obs, expv);
            end
            if (k == 1) begin
                total++;
                if (obs[5:4] !== 2'b00) begin
                    bad++;
                    $display("FAIL midrst_abort got sov/so=%b want=00", obs[5:4]);
                end
            end
        end
        rst = 1'b0;
        step();
        total++;
        if (obs[1:0] !== 2'b10 || obs !== expv) begin
            bad++;
            $display("FAIL midrst_tie got=%b want=%b", obs, expv);
        end
        n = 0;
        while ((w0_q.size() + w1_q.size() + sb.size()) != 0 && n < 20) begin
            step();
            n++;
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL midrst_drain cyc%0d got=%b want=%b", n, obs, expv);
            end
        end
    endtask

    task automatic test_width8();
        logic [7:0] d;
        logic [3:0] q8[$];
        logic [3:0] o8, e8;
        d = 8'hC3;
        bus8.req1_valid = 1'b1;
        bus8.req1_data  = d;
        @(negedge clk);
        total++;
        if ({bus8.req0_ready, bus8.req1_ready} !== 2'b01) begin
            bad++;
            $display("FAIL w8_ready got=%b want=01", {bus8.req0_ready, bus8.req1_ready});
        end
        for (int i = 7; i >= 0; i--) q8.push_back({1'b1, d[i], (i == 7), 1'b1});
        @(posedge clk);
        #1;
        bus8.req1_valid = 1'b0;
        bus8.req1_data  = 8'h00;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            o8 = {bus8.so_valid, bus8.so, bus8.frame_start, bus8.grant_id};
            e8 = (q8.size() != 0) ? q8.pop_front() : 4'b0001;
            total++;
            if (o8 !== e8) begin
                bad++;
                $display("FAIL w8 cyc%0d got=%b want=%b", k, o8, e8);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus4.req0_valid = 1'b0; bus4.req0_data = 4'h0;
        bus4.req1_valid = 1'b0; bus4.req1_data = 4'h0;
        bus8.req0_valid = 1'b0; bus8.req0_data = 8'h00;
        bus8.req1_valid = 1'b0; bus8.req1_data = 8'h00;
        test_reset();
        test_simultaneous();
        test_contention();
        test_late_req1();
        test_single();
        test_reset_midframe();
        test_width8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
